// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  // Width able to hold a beat count of 0..max_burst.
  function automatic int unsigned beat_cnt_w(input int unsigned max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request scanning upward from start_i, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      start_i,
  output logic [IW-1:0]      winner_o,
  output logic               any_req_o
);

  int unsigned idx;

  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(start_i) + i) % NUM_REQ;
      if (!any_req_o && req_i[idx]) begin
        any_req_o = 1'b1;
        winner_o  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one FIFO push port among NUM_REQ producers.
// Optional per-requester beat counters are built when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned IW         = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_valid_s,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data_s,
  output logic [NUM_REQ-1:0]            o_ready_s,
  output logic                          o_valid_m,
  output logic [DATA_WIDTH-1:0]         o_data_m,
  output logic [IW-1:0]                 o_src_id,
  input  logic                          i_ready_m
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         o_beat_cnt
`endif
);

  localparam int unsigned BW = beat_cnt_w(MAX_BURST);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]   winner;
  logic            any_req;
  logic [IW-1:0]   next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .req_i     (i_valid_s),
    .start_i   (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  assign next_ptr = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);
  assign o_src_id = grant_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    o_valid_m  = 1'b0;
    o_data_m   = '0;
    o_ready_s  = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d    = winner;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        o_valid_m          = i_valid_s[grant_q];
        o_data_m           = i_data_s[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
        // Ready depends only on the FIFO, never on the requester's valid.
        o_ready_s[grant_q] = i_ready_m;
        if (!i_valid_s[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (i_ready_m) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (beat_cnt_q == BW'(MAX_BURST - 1)) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stat_q [NUM_REQ];
  logic [15:0] stat_d [NUM_REQ];

  // Saturating count of beats accepted from each requester.
  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      stat_d[k] = stat_q[k];
      if (o_ready_s[k] && i_valid_s[k] && (stat_q[k] != 16'hFFFF)) begin
        stat_d[k] = stat_q[k] + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (i_rst) begin
        stat_q[k] <= '0;
      end else begin
        stat_q[k] <= stat_d[k];
      end
    end
  end

  always_comb begin
    o_beat_cnt = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      o_beat_cnt[k*16 +: 16] = stat_q[k];
    end
  end
`else
  // No statistics counters in this build.
`endif

endmodule
